// File: rtl/lowf_fir_mac.sv
// rtl/lowf_fir_mac.sv - low-band FIR multiply-accumulate consumer of the low-frequency sample queue
module lowf_fir_mac #(
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sequencing,
    input  logic signed [15:0]       smpl_in,
    input  logic signed [15:0]       coeff,
    output logic        [ADDR_W-1:0] coeff_addr,
    output logic signed [15:0]       smpl_out,
    output logic                     smpl_vld,
    output logic                     seq_err
);

    // Sum of TAPS full-scale products cannot overflow this width.
    localparam int ACC_W = 32 + $clog2(TAPS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'((TAPS > 1) ? TAPS - 2 : 0);

    localparam logic signed [ACC_W-1:0] HALF_LSB = {{(ACC_W-15){1'b0}}, 15'h4000};
    localparam logic signed [ACC_W-1:0] MAX_OUT  = {{(ACC_W-15){1'b0}}, 15'h7FFF};
    localparam logic signed [ACC_W-1:0] MIN_OUT  = {{(ACC_W-15){1'b1}}, 15'h0000};

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        WAIT_LOW
    } state_t;

    state_t state;
    logic [1:0] drain_cnt;

    // Pipeline valid flags: tap issued, operands arriving, operands registered, product registered.
    logic issue_v;
    logic data_v;
    logic pair_v;
    logic prod_v;

    logic signed [15:0]      smpl_r;
    logic signed [15:0]      coeff_r;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] final_sum;
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] scaled;
    logic signed [15:0]      sat_out;

    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

    // Final tap's product is folded in here during DONE, then rounded half-up and clamped.
    always_comb begin
        final_sum = acc + prod_ext;
        rounded   = final_sum + HALF_LSB;
        scaled    = rounded >>> 15;
        sat_out   = scaled[15:0];
        if (scaled > MAX_OUT) begin
            sat_out = 16'sh7FFF;
        end else if (scaled < MIN_OUT) begin
            sat_out = 16'sh8000;
        end
    end

    // Frame sequencing FSM together with the operand/product/accumulate pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= 2'd0;
            coeff_addr <= '0;
            smpl_out   <= 16'sh0;
            smpl_vld   <= 1'b0;
            seq_err    <= 1'b0;
            issue_v    <= 1'b0;
            data_v     <= 1'b0;
            pair_v     <= 1'b0;
            prod_v     <= 1'b0;
            smpl_r     <= 16'sh0;
            coeff_r    <= 16'sh0;
            prod       <= 32'sh0;
            acc        <= '0;
        end else begin
            smpl_vld <= 1'b0;
            seq_err  <= 1'b0;
            issue_v  <= 1'b0;

            data_v  <= issue_v;
            pair_v  <= data_v;
            prod_v  <= pair_v;
            smpl_r  <= smpl_in;
            coeff_r <= coeff;
            prod    <= 32'(smpl_r) * 32'(coeff_r);
            if (prod_v) begin
                acc <= acc + prod_ext;
            end

            case (state)
                IDLE: begin
                    coeff_addr <= '0;
                    if (sequencing) begin
                        issue_v   <= 1'b1;
                        drain_cnt <= 2'd0;
                        state     <= (TAPS == 1) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (sequencing) begin
                        issue_v    <= 1'b1;
                        coeff_addr <= coeff_addr + 1'b1;
                        if (coeff_addr == PRE_LAST) begin
                            drain_cnt <= 2'd0;
                            state     <= DRAIN;
                        end
                    end else begin
                        // Short burst: drop everything in flight so no stale product lands later.
                        seq_err    <= 1'b1;
                        coeff_addr <= '0;
                        acc        <= '0;
                        data_v     <= 1'b0;
                        pair_v     <= 1'b0;
                        prod_v     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    coeff_addr <= '0;
                    drain_cnt  <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    smpl_out <= sat_out;
                    smpl_vld <= 1'b1;
                    acc      <= '0;
                    state    <= sequencing ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!sequencing) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    coeff_addr <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // coeff_addr only ever holds tap indices.
    logic unused_last;
    assign unused_last = (LAST_ADDR == '0);

endmodule

// File: tb/tb_lowf_fir_mac.sv
// tb/tb_lowf_fir_mac.sv - table-driven scoreboard bench for lowf_fir_mac (TAPS=4 and default TAPS)
module tb_lowf_fir_mac;

    localparam int NB = 1021;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               seq_a, seq_b;
    logic signed [15:0] smpl_a, coeff_a, smpl_b, coeff_b;
    logic        [9:0]  addr_a, addr_b;
    logic signed [15:0] out_a, out_b;
    logic               vld_a, vld_b, err_a, err_b;

    lowf_fir_mac #(.TAPS(4), .ADDR_W(10)) u_a (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_a), .smpl_in(smpl_a), .coeff(coeff_a),
        .coeff_addr(addr_a), .smpl_out(out_a), .smpl_vld(vld_a), .seq_err(err_a)
    );

    lowf_fir_mac u_b (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_b), .smpl_in(smpl_b), .coeff(coeff_b),
        .coeff_addr(addr_b), .smpl_out(out_b), .smpl_vld(vld_b), .seq_err(err_b)
    );

    // Queue RAM and coefficient ROM models, one-cycle read latency.
    logic signed [15:0] rom_a [4];
    logic signed [15:0] ram_a [4];
    logic signed [15:0] rom_b [2][NB];
    logic signed [15:0] ram_b [2][NB];
    int sel_b = 0;

    always @(posedge clk) begin
        coeff_a <= rom_a[addr_a[1:0]];
        smpl_a  <= ram_a[addr_a[1:0]];
        coeff_b <= rom_b[sel_b][addr_b];
        smpl_b  <= ram_b[sel_b][addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic signed [15:0] v;
        int                 at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int vld_cnt_a = 0, err_cnt_a = 0, vld_cnt_b = 0;

    // Output monitors: pop the scoreboard on every smpl_vld.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld_a || err_a) check("a_vld_err_excl", {31'b0, vld_a & err_a}, 32'h0);
            if (err_a) err_cnt_a++;
            if (vld_a) begin
                exp_t e;
                vld_cnt_a++;
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_vld: got smpl_out %0h with nothing expected (cycle %0d)", out_a, cyc);
                end else begin
                    e = q_a.pop_front();
                    check("a_smpl_out", out_a, e.v);
                    check("a_latency", cyc, e.at);
                end
            end
            if (vld_b) begin
                exp_t e;
                vld_cnt_b++;
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_vld: got smpl_out %0h with nothing expected (cycle %0d)", out_b, cyc);
                end else begin
                    e = q_b.pop_front();
                    check("b_smpl_out", out_b, e.v);
                    check("b_latency", cyc, e.at);
                end
            end
        end
    end

    typedef struct {
        logic signed [15:0] c [4];
        logic signed [15:0] s [4];
        logic signed [15:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic set_vec(input int i, input logic [15:0] c0, c1, c2, c3,
                           input logic [15:0] s0, s1, s2, s3, input logic [15:0] e);
        tbl[i].c[0] = c0; tbl[i].c[1] = c1; tbl[i].c[2] = c2; tbl[i].c[3] = c3;
        tbl[i].s[0] = s0; tbl[i].s[1] = s1; tbl[i].s[2] = s2; tbl[i].s[3] = s3;
        tbl[i].exp = e;
    endtask

    function automatic logic signed [15:0] round_sat(input longint sum);
        longint r;
        r = (sum + 64'sd16384) >>> 15;
        if (r > 64'sd32767) return 16'sh7FFF;
        if (r < -64'sd32768) return 16'sh8000;
        return r[15:0];
    endfunction

    // Drives one TAPS=4 burst of 'hi' high samples; expects an output when the burst is full length.
    task automatic frame_a(input int hi, input int idx, output int start);
        for (int i = 0; i < 4; i++) begin
            rom_a[i] = tbl[idx].c[i];
            ram_a[i] = tbl[idx].s[i];
        end
        seq_a = 1'b1;
        start = cyc + 1;
        if (hi >= 4) q_a.push_back('{tbl[idx].exp, start + 7});
        repeat (hi) @(negedge clk);
        seq_a = 1'b0;
    endtask

    task automatic wait_q(input int which, input int budget);
        int n = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (((which == 0) ? q_a.size() : q_b.size()) != 0) begin
            errors++;
            $display("FAIL timeout_%0d: got no smpl_vld within %0d cycles", which, budget);
            if (which == 0) q_a.delete(); else q_b.delete();
        end
    endtask

    task automatic frame_b(input int f, output int start);
        longint sum = 0;
        for (int i = 0; i < NB; i++) sum += longint'(ram_b[f][i]) * longint'(rom_b[f][i]);
        sel_b = f;
        seq_b = 1'b1;
        start = cyc + 1;
        q_b.push_back('{round_sat(sum), start + NB + 3});
        repeat (NB) @(negedge clk);
        seq_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, e0, v0;
        seq_a = 1'b0;
        seq_b = 1'b0;
        for (int i = 0; i < 4; i++) begin rom_a[i] = 16'sh0; ram_a[i] = 16'sh0; end
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NB; i++) begin
                rom_b[f][i] = 16'($urandom);
                ram_b[f][i] = 16'($urandom);
            end

        set_vec(0, 16'h4000, 16'h2000, 16'h0000, 16'h0000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd750);
        set_vec(1, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1);
        set_vec(2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_vec(3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        set_vec(4, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0);
        set_vec(5, 16'h2000, 16'hE000, 16'h4000, 16'h1000, 16'd100, 16'd300, 16'hFFCE, 16'd800, 16'd25);
        set_vec(6, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF);

        repeat (3) @(negedge clk);
        check("rst_addr_a", {22'b0, addr_a}, 32'h0);
        check("rst_out_a", {16'b0, out_a}, 32'h0);
        check("rst_vld_a", {31'b0, vld_a}, 32'h0);
        check("rst_err_a", {31'b0, err_a}, 32'h0);
        check("rst_addr_b", {22'b0, addr_b}, 32'h0);
        check("rst_out_b", {16'b0, out_b}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            frame_a(4, i, st);
            wait_q(0, 40);
            repeat (3) @(negedge clk);
        end

        // Short burst: error pulse, no output, previous output held, then a clean frame.
        e0 = err_cnt_a;
        v0 = vld_cnt_a;
        frame_a(2, 0, st);
        @(negedge clk);
        check("abort_err_cycle2", {31'b0, err_a}, 32'h1);
        check("abort_addr_zero", {22'b0, addr_a}, 32'h0);
        repeat (10) @(negedge clk);
        check("abort_err_count", err_cnt_a - e0, 32'd1);
        check("abort_no_vld", vld_cnt_a - v0, 32'd0);
        check("abort_out_held", {16'b0, out_a}, {16'b0, tbl[6].exp});
        frame_a(4, 0, st);
        wait_q(0, 40);
        repeat (3) @(negedge clk);

        // Over-long burst: exactly one output, address parked at 0.
        v0 = vld_cnt_a;
        for (int i = 0; i < 4; i++) begin rom_a[i] = tbl[5].c[i]; ram_a[i] = tbl[5].s[i]; end
        seq_a = 1'b1;
        st = cyc + 1;
        q_a.push_back('{tbl[5].exp, st + 7});
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i >= 4) check("long_addr_zero", {22'b0, addr_a}, 32'h0);
        end
        seq_a = 1'b0;
        wait_q(0, 40);
        repeat (6) @(negedge clk);
        check("long_one_vld", vld_cnt_a - v0, 32'd1);

        // Minimum spacing: next burst starts in the cycle DONE returns to IDLE.
        frame_a(4, 0, st);
        repeat (4) @(negedge clk);
        frame_a(4, 1, st);
        wait_q(0, 40);
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame.
        v0 = vld_cnt_a;
        e0 = err_cnt_a;
        for (int i = 0; i < 4; i++) begin rom_a[i] = tbl[5].c[i]; ram_a[i] = tbl[5].s[i]; end
        seq_a = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_addr_before", {22'b0, addr_a}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_addr", {22'b0, addr_a}, 32'h0);
        check("midrst_out", {16'b0, out_a}, 32'h0);
        check("midrst_vld", {31'b0, vld_a}, 32'h0);
        check("midrst_err", {31'b0, err_a}, 32'h0);
        seq_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_vld", vld_cnt_a - v0, 32'd0);
        check("midrst_no_err", err_cnt_a - e0, 32'd0);
        check("midrst_out_after", {16'b0, out_a}, 32'h0);

        // Default-size block: two frames at minimum spacing with random data.
        frame_b(0, st);
        repeat (4) @(negedge clk);
        frame_b(1, st);
        wait_q(1, 1200);
        repeat (4) @(negedge clk);
        check("b_two_vld", vld_cnt_b, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lowf_fir_mac.md
# lowf_fir_mac

Sequencing-side consumer of the low-frequency sample queue. While the queue asserts `sequencing` and streams one stored sample per clock, this block drives the coefficient ROM address in lock-step. It multiply-accumulates each sample/coefficient pair, then rounds and saturates the sum to one filtered 16-bit output sample. It sits between the low-frequency queue and the audio output mixer, one instance per low-band channel.

## Interface
- `TAPS`, 1021: samples and coefficients per frame, i.e. the queue's burst length.
- `ADDR_W`, 10: coefficient address width; `TAPS` ≤ 2^ADDR_W.
- `clk`  input  1  single system clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sequencing`  input  1  high while the queue streams a frame; one sample address per high cycle.
- `smpl_in`  input  16  signed sample from queue RAM; 1-cycle read latency behind the address issued while `sequencing` was high.
- `coeff`  input  16  signed Q1.15 coefficient from external ROM; 1-cycle latency behind `coeff_addr`.
- `coeff_addr`  output  ADDR_W  registered ROM address = current tap index.
- `smpl_out`  output  16  signed filtered sample; holds its value between frames.
- `smpl_vld`  output  1  one-cycle pulse when `smpl_out` updates.
- `seq_err`  output  1  one-cycle pulse when a frame aborts early.

## Operation
- States: IDLE, RUN, DRAIN, DONE, WAIT_LOW.
- IDLE: `coeff_addr`=0, accumulator=0. `sequencing` sampled high → RUN. This cycle is cycle 0, tap 0 issued.
- RUN: each cycle with `sequencing` high, tap counter k advances; `coeff_addr`=k in cycle k, k=0..TAPS-1.
  - After issuing tap TAPS-1 → DRAIN.
  - `sequencing` sampled low before tap TAPS-1 is issued: pulse `seq_err` next cycle, clear accumulator and counter, → IDLE, no `smpl_vld`.
- Datapath is a 3-stage pipeline per tap:
  - Cycle k+1: `smpl_in` and `coeff` pair valid and registered.
  - Cycle k+2: 32-bit signed product registered.
  - Cycle k+3: product added to accumulator.
- DRAIN: 3 cycles, flushes the pipeline. `sequencing` is ignored. → DONE.
- DONE:
  - `smpl_out` ← sat16((acc + 2^14) >>> 15): arithmetic shift, round half toward +∞, clamp to [0x8000, 0x7FFF].
  - `smpl_vld`=1 for this cycle only.
  - Clear accumulator. → WAIT_LOW if `sequencing` high, else IDLE.
- WAIT_LOW: hold until `sequencing` is sampled low, then → IDLE. Over-long bursts never start a second frame.
- Accumulator width: ACC_W = 32 + clog2(TAPS), i.e. 42 for the default. No internal overflow is possible; saturation is applied only at output.
- Arithmetic is fully signed (two's complement) throughout.

## Timing
- Reset values: `coeff_addr`=0, `smpl_out`=0, `smpl_vld`=0, `seq_err`=0, state IDLE, accumulator and pipeline registers 0.
- Reset mid-frame clears everything immediately and asynchronously. No pulse is emitted for the aborted frame.
- Latency: `smpl_vld` high in cycle TAPS+3 relative to cycle 0, i.e. 1024 cycles at default.
- Minimum frame spacing: `sequencing` low ≥1 cycle between frames. `sequencing` re-rising in the cycle DONE exits to IDLE starts a new frame from that cycle.
- `seq_err` is asserted in the cycle after the low sample. `smpl_vld` and `seq_err` are never high together.
- `coeff_addr` never exceeds TAPS-1. It returns to 0 in the cycle after RUN ends or aborts.

## Test plan
- TAPS=4, coeffs [0x4000,0x2000,0,0], samples [1000,1000,1000,1000], `sequencing` high 4 cycles → `smpl_vld` in cycle 7, `smpl_out`=750.
- TAPS=4, coeffs [0x4000,0,0,0], samples [1,0,0,0] → `smpl_out`=1 (half rounds up).
- TAPS=4, all coeffs 0x7FFF:
  - all samples 0x7FFF → `smpl_out`=0x7FFF (positive saturation).
  - all samples 0x8000 → `smpl_out`=0x8000 (negative saturation).
- TAPS=4, `sequencing` high only cycles 0-1 → `seq_err` pulse in cycle 2, no `smpl_vld`, `smpl_out` unchanged. A following full frame produces correct output.
- TAPS=4, `sequencing` high 9 cycles → exactly one `smpl_vld` (cycle 7), `coeff_addr` stays 0 after cycle 4. `rst_n` pulsed low at cycle 2 of a frame → all outputs 0, no pulse.
- Default TAPS=1021: two back-to-back frames with random samples and coefficients → each `smpl_out` matches the reference model bit-exactly; `smpl_vld` at cycle 1024 of each frame.
